bure_mem_responder: RTL and testbench
=====================================

Name: bure_mem_responder

Overview:
- Memory-side responder for the cg_memory_interface read/write protocol. It serves the fetch and load/store initiators from a word-addressed on-chip array.
- Read path: configurable fixed latency pipeline feeding a small response queue, so the initiator can stream back-to-back addresses and apply backpressure through rdata_ready.
- Write path: fire-and-forget, with no write handshake back to the initiator.
- Sits between the core's memory-interface initiators and local instruction/data RAM. Also serves as the memory model in stage benches.

Parameters:
- DATA_WIDTH, 32, word width; byte address LSBs [1:0] ignored.
- ADDR_WIDTH, 32, byte address width.
- DEPTH_WORDS, 1024, number of words (power of two); index = addr[log2(DEPTH_WORDS)+1:2].
- READ_LATENCY, 1, cycles from read accept to first possible rdata_valid; legal 1..4.
- MAX_OUTSTANDING, 2, maximum reads accepted but not yet consumed (in pipeline plus queue); legal 1..8.
- INIT_FILE, "", hex image loaded with $readmemh at elaboration if non-empty.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_raddr_valid  in  1  initiator presents a read address.
- o_raddr_ready  out  1  responder can accept a read address.
- i_raddr  in  ADDR_WIDTH  read byte address.
- o_rdata_valid  out  1  head-of-queue read data valid.
- i_rdata_ready  in  1  initiator consumes rdata.
- o_rdata  out  DATA_WIDTH  read data.
- i_wen  in  1  write enable.
- i_wdata_valid  in  1  write data valid.
- i_waddr  in  ADDR_WIDTH  write byte address.
- i_wdata  in  DATA_WIDTH  write data.

Behaviour:
- One clock, i_clk. i_rstn is asynchronous assert, active-low.
- Reset values: o_rdata_valid=0, o_rdata='0. Pipeline valids and queue pointers/count cleared. o_raddr_ready=0 while i_rstn low.
- Array contents are not reset; they hold INIT_FILE or prior writes.

Read accept:
- A read is accepted on a rising edge where i_raddr_valid & o_raddr_ready.
- o_raddr_ready = (reads in pipeline + entries in queue) < MAX_OUTSTANDING. It is combinational from registered counts and never depends on i_raddr_valid.
- The address is captured at the accept edge. Later changes to i_raddr do not affect the accepted read.

Read latency:
- Read accepted at edge N with the queue empty and i_rdata_ready=1 gives o_rdata_valid=1 with the correct word from edge N+READ_LATENCY.
- Back-to-back accepts with i_rdata_ready held 1 give one response per cycle, in order, with no bubbles. MAX_OUTSTANDING must be >= READ_LATENCY+1 for full throughput; fewer gives proportional bubbles, never loss.

Response queue:
- In-order FIFO of depth MAX_OUTSTANDING. o_rdata_valid = queue non-empty, and o_rdata = head entry.
- Pop on edge where o_rdata_valid & i_rdata_ready.
- While o_rdata_valid=1 and i_rdata_ready=0, o_rdata is held stable.
- Simultaneous push and pop is allowed, and the count is unchanged.
- Overflow is impossible by the ready rule. An assertion must check it.
- Accept and pop on the same edge: count +1-1. The ready update reflects both.

Writes:
- On an edge with i_wen & i_wdata_valid, i_wdata is written to the word at i_waddr. There is no backpressure.

Read/write ordering:
- Same-edge read accept and write to the same word: the read returns the OLD data (read-first).
- A read accepted on any later edge returns the new data.

Address handling:
- Index wraps modulo DEPTH_WORDS; upper address bits are ignored.
- Byte offset bits [1:0] are ignored; misaligned addresses read the containing word.

Reset mid-operation:
- In-flight and queued reads are discarded.
- No response is ever delivered for a read accepted before reset.
- Array contents persist.

Invariants (assertions):
- Count never exceeds MAX_OUTSTANDING.
- o_rdata_valid never falls without a pop or reset.
- o_rdata is stable while stalled.

Test Plan:
- READ_LATENCY=1, INIT word[4]=0xDEADBEEF: read i_raddr=0x10 accepted at edge 0, i_rdata_ready=1 -> o_rdata_valid=1, o_rdata=0xDEADBEEF from edge 1, then 0 at edge 2.
- READ_LATENCY=2, MAX_OUTSTANDING=3, addresses 0x0,0x4,0x8,0xC on consecutive edges, ready=1 -> data words 0..3 valid on four consecutive cycles starting at edge 2, o_raddr_ready never drops.
- MAX_OUTSTANDING=2, i_rdata_ready=0, continuous requests -> exactly 2 accepted, o_raddr_ready=0 thereafter, and the first response is held stable. Raising ready -> in-order drain, then ready reasserts.
- Write 0x12345678 to 0x20 and read 0x20 on the same edge -> old value returned. Read on the next edge -> 0x12345678.
- DEPTH_WORDS=1024, write 0xA5A5A5A5 to 0x1004 -> read 0x0004 and read 0x0007 both return 0xA5A5A5A5.
- Two reads accepted, i_rstn pulsed low mid-latency -> o_rdata_valid=0 immediately. No stale response after release, and array data still readable.

Source files
------------

// File: rtl/bure_mem_responder_if.sv
// Bus bundle between memory-interface initiators and the on-chip memory responder.
// Read address/data handshakes plus a fire-and-forget write port.
interface bure_mem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  i_raddr_valid;
  logic                  o_raddr_ready;
  logic [ADDR_WIDTH-1:0] i_raddr;
  logic                  o_rdata_valid;
  logic                  i_rdata_ready;
  logic [DATA_WIDTH-1:0] o_rdata;
  logic                  i_wen;
  logic                  i_wdata_valid;
  logic [ADDR_WIDTH-1:0] i_waddr;
  logic [DATA_WIDTH-1:0] i_wdata;

  modport master (
    output i_raddr_valid, i_raddr, i_rdata_ready,
    output i_wen, i_wdata_valid, i_waddr, i_wdata,
    input  o_raddr_ready, o_rdata_valid, o_rdata
  );

  modport slave (
    input  i_raddr_valid, i_raddr, i_rdata_ready,
    input  i_wen, i_wdata_valid, i_waddr, i_wdata,
    output o_raddr_ready, o_rdata_valid, o_rdata
  );
endinterface

// File: rtl/bure_mem_responder.sv
// Word-addressed on-chip memory responder: fixed-latency read pipeline feeding an
// in-order response queue with backpressure, plus an unhandshaked write port.
module bure_mem_responder #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter              INIT_FILE       = ""
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  bure_mem_responder_if.slave  bus
);

  localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned OCC_W  = $clog2(MAX_OUTSTANDING + READ_LATENCY + 1);
  localparam int unsigned PIPE_N = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [OCC_W-1:0] MAX_OCC  = OCC_W'(MAX_OUTSTANDING);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Read pipeline: the array is read at the accept edge, so a same-edge write
  // is not yet visible; each stage adds one cycle before the queue push.
  logic [PIPE_N-1:0]                 pipe_vld_q,  pipe_vld_d;
  logic [PIPE_N-1:0][DATA_WIDTH-1:0] pipe_data_q, pipe_data_d;

  logic [MAX_OUTSTANDING-1:0][DATA_WIDTH-1:0] q_data_q, q_data_d;
  logic [PTR_W-1:0]                           q_wr_q,   q_wr_d;
  logic [PTR_W-1:0]                           q_rd_q,   q_rd_d;
  logic [CNT_W-1:0]                           q_count_q, q_count_d;

  logic [IDX_W-1:0]      ridx;
  logic [IDX_W-1:0]      widx;
  logic [OCC_W-1:0]      occ;
  logic                  raddr_ready;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop;
  logic                  q_nonempty;
  logic                  unused_bits;

  always_comb begin
    ridx = bus.i_raddr[IDX_W+1:2];
    widx = bus.i_waddr[IDX_W+1:2];
    unused_bits = ^{bus.i_raddr, bus.i_waddr, pipe_vld_q, pipe_data_q};
  end

  // Outstanding count is purely registered, so ready never depends on i_raddr_valid.
  always_comb begin
    occ = OCC_W'(q_count_q);
    for (int unsigned k = 0; k < PIPE_N; k++) begin
      occ = occ + OCC_W'(pipe_vld_q[k]);
    end
    raddr_ready = i_rstn && (occ < MAX_OCC);
    accept      = bus.i_raddr_valid && raddr_ready;
    rd_word     = mem[ridx];
  end

  always_comb begin
    pipe_vld_d     = '0;
    pipe_data_d    = pipe_data_q;
    pipe_vld_d[0]  = (READ_LATENCY > 1) ? accept : 1'b0;
    pipe_data_d[0] = rd_word;
    for (int unsigned k = 1; k < PIPE_N; k++) begin
      pipe_vld_d[k]  = pipe_vld_q[k-1];
      pipe_data_d[k] = pipe_data_q[k-1];
    end
    push      = (READ_LATENCY > 1) ? pipe_vld_q[PIPE_N-1]  : accept;
    push_data = (READ_LATENCY > 1) ? pipe_data_q[PIPE_N-1] : rd_word;
  end

  always_comb begin
    q_nonempty = (q_count_q != '0);
    pop        = q_nonempty && bus.i_rdata_ready;
    q_data_d   = q_data_q;
    q_wr_d     = q_wr_q;
    q_rd_d     = q_rd_q;
    if (push) begin
      q_data_d[q_wr_q] = push_data;
      q_wr_d = (q_wr_q == PTR_LAST) ? '0 : q_wr_q + 1'b1;
    end
    if (pop) begin
      q_rd_d = (q_rd_q == PTR_LAST) ? '0 : q_rd_q + 1'b1;
    end
    q_count_d = q_count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    bus.o_raddr_ready = raddr_ready;
    bus.o_rdata_valid = q_nonempty;
    bus.o_rdata       = q_nonempty ? q_data_q[q_rd_q] : '0;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pipe_vld_q  <= '0;
      pipe_data_q <= '0;
      q_data_q    <= '0;
      q_wr_q      <= '0;
      q_rd_q      <= '0;
      q_count_q   <= '0;
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      pipe_data_q <= pipe_data_d;
      q_data_q    <= q_data_d;
      q_wr_q      <= q_wr_d;
      q_rd_q      <= q_rd_d;
      q_count_q   <= q_count_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge i_clk) begin
    if (bus.i_wen && bus.i_wdata_valid) begin
      mem[widx] <= bus.i_wdata;
    end
  end

  a_count_bound: assert property (@(posedge i_clk) disable iff (!i_rstn)
    (q_count_q <= MAX_CNT) && (occ <= MAX_OCC));

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn)
    (push && !pop) |-> (q_count_q < MAX_CNT));

  a_stall_hold: assert property (@(posedge i_clk) disable iff (!i_rstn)
    (bus.o_rdata_valid && !bus.i_rdata_ready) |=> (bus.o_rdata_valid && $stable(bus.o_rdata)));

endmodule

// File: tb/tb_bure_mem_responder.sv
// Bench for bure_mem_responder: queue-with-timestamps reference model checked every
// cycle, directed literal cases, then randomized traffic with occasional resets.
module tb_bure_mem_responder;
  localparam int LAT   = 2;
  localparam int MAXO  = 3;
  localparam int DEPTH = 1024;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  bure_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  bure_mem_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH),
    .READ_LATENCY(LAT), .MAX_OUTSTANDING(MAXO), .INIT_FILE("")
  ) dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: accepted reads are a FIFO of (word, edge-count when visible).
  typedef struct {
    logic [31:0] data;
    int          avail;
  } resp_t;

  resp_t       q[$];
  logic [31:0] mem_m [DEPTH];
  int          edges = 0;

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  always @(posedge clk) edges <= edges + 1;

  always @(negedge clk) begin : compare
    logic ev;
    logic er;
    if (!rstn) begin
      q.delete();
      check1("rst_ready", bus.o_raddr_ready, 1'b0);
      check1("rst_valid", bus.o_rdata_valid, 1'b0);
      check32("rst_rdata", bus.o_rdata, 32'h0);
    end else begin
      er = (q.size() < MAXO);
      ev = (q.size() > 0) && (q[0].avail <= edges);
      check1("model_ready", bus.o_raddr_ready, er);
      check1("model_valid", bus.o_rdata_valid, ev);
      if (ev) check32("model_rdata", bus.o_rdata, q[0].data);
      if (ev && bus.i_rdata_ready) void'(q.pop_front());
      if (bus.i_raddr_valid && er)
        q.push_back('{data: mem_m[word_of(bus.i_raddr)], avail: edges + LAT});
      if (bus.i_wen && bus.i_wdata_valid)
        mem_m[word_of(bus.i_waddr)] = bus.i_wdata;
    end
  end

  task automatic idle();
    bus.i_raddr_valid = 1'b0;
    bus.i_raddr       = '0;
    bus.i_rdata_ready = 1'b1;
    bus.i_wen         = 1'b0;
    bus.i_wdata_valid = 1'b0;
    bus.i_waddr       = '0;
    bus.i_wdata       = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    repeat (3) tick();
    rstn = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      bus.i_wen         = 1'b1;
      bus.i_wdata_valid = 1'b1;
      bus.i_waddr       = 32'(i * 4);
      bus.i_wdata       = $urandom;
      if (i < 4)  bus.i_wdata = 32'h100 + 32'(i);
      if (i == 4) bus.i_wdata = 32'hDEADBEEF;
      if (i == 8) bus.i_wdata = 32'h55AA0008;
      tick();
    end
    idle();
    tick();

    // Single read, latency 2
    bus.i_raddr_valid = 1'b1; bus.i_raddr = 32'h10;
    tick();
    bus.i_raddr_valid = 1'b0;
    check1("lat_early_valid", bus.o_rdata_valid, 1'b0);
    tick();
    check1("lat_valid", bus.o_rdata_valid, 1'b1);
    check32("lat_rdata", bus.o_rdata, 32'hDEADBEEF);
    tick();
    check1("lat_drop", bus.o_rdata_valid, 1'b0);

    // Back-to-back stream with ready held high
    bus.i_raddr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.i_raddr = 32'(i * 4);
      tick();
      check1("stream_ready", bus.o_raddr_ready, 1'b1);
      if (i == 0) check1("stream_first", bus.o_rdata_valid, 1'b0);
      else        check32("stream_rdata", bus.o_rdata, 32'h100 + 32'(i - 1));
    end
    bus.i_raddr_valid = 1'b0;
    tick();
    check32("stream_last", bus.o_rdata, 32'h103);
    tick();
    check1("stream_end", bus.o_rdata_valid, 1'b0);

    // Backpressure: exactly MAXO accepted, head held
    bus.i_rdata_ready = 1'b0;
    bus.i_raddr_valid = 1'b1; bus.i_raddr = 32'h0;
    tick();
    check1("bp_ready0", bus.o_raddr_ready, 1'b1);
    bus.i_raddr = 32'h4;
    tick();
    check1("bp_ready1", bus.o_raddr_ready, 1'b1);
    check32("bp_head1", bus.o_rdata, 32'h100);
    bus.i_raddr = 32'h8;
    tick();
    check1("bp_full", bus.o_raddr_ready, 1'b0);
    bus.i_raddr = 32'hC;
    for (int i = 0; i < 3; i++) begin
      tick();
      check1("bp_hold_ready", bus.o_raddr_ready, 1'b0);
      check1("bp_hold_valid", bus.o_rdata_valid, 1'b1);
      check32("bp_hold_rdata", bus.o_rdata, 32'h100);
    end
    bus.i_raddr_valid = 1'b0; bus.i_rdata_ready = 1'b1;
    tick();
    check32("drain1", bus.o_rdata, 32'h101);
    check1("drain_ready", bus.o_raddr_ready, 1'b1);
    tick();
    check32("drain2", bus.o_rdata, 32'h102);
    tick();
    check1("drain_empty", bus.o_rdata_valid, 1'b0);

    // Same-edge read and write: old data, then new data
    bus.i_raddr_valid = 1'b1; bus.i_raddr = 32'h20;
    bus.i_wen = 1'b1; bus.i_wdata_valid = 1'b1; bus.i_waddr = 32'h20; bus.i_wdata = 32'h12345678;
    tick();
    bus.i_wen = 1'b0; bus.i_wdata_valid = 1'b0;
    tick();
    check32("rw_old", bus.o_rdata, 32'h55AA0008);
    bus.i_raddr_valid = 1'b0;
    tick();
    check32("rw_new", bus.o_rdata, 32'h12345678);
    tick();

    // Index wrap and byte-offset aliasing
    bus.i_wen = 1'b1; bus.i_wdata_valid = 1'b1; bus.i_waddr = 32'h1004; bus.i_wdata = 32'hA5A5A5A5;
    tick();
    bus.i_wen = 1'b0; bus.i_wdata_valid = 1'b0;
    bus.i_raddr_valid = 1'b1; bus.i_raddr = 32'h4;
    tick();
    bus.i_raddr = 32'h7;
    tick();
    check32("alias_0004", bus.o_rdata, 32'hA5A5A5A5);
    bus.i_raddr_valid = 1'b0;
    tick();
    check32("alias_0007", bus.o_rdata, 32'hA5A5A5A5);
    tick();

    // Reset mid-latency discards in-flight reads, keeps array
    bus.i_raddr_valid = 1'b1; bus.i_raddr = 32'h10;
    tick();
    bus.i_raddr = 32'h0;
    tick();
    rstn = 1'b0; bus.i_raddr_valid = 1'b0;
    #1;
    check1("rst_mid_valid", bus.o_rdata_valid, 1'b0);
    check1("rst_mid_ready", bus.o_raddr_ready, 1'b0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check1("rst_no_stale", bus.o_rdata_valid, 1'b0);
    end
    bus.i_raddr_valid = 1'b1; bus.i_raddr = 32'h10;
    tick();
    bus.i_raddr_valid = 1'b0;
    tick();
    check32("rst_persist", bus.o_rdata, 32'hDEADBEEF);
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (!rstn) rstn = 1'b1;
      else if ($urandom_range(0, 399) == 0) rstn = 1'b0;
      bus.i_raddr_valid = ($urandom_range(0, 3) != 0);
      bus.i_raddr       = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      bus.i_rdata_ready = ($urandom_range(0, 2) != 0);
      bus.i_wen         = rstn && ($urandom_range(0, 2) == 0);
      bus.i_wdata_valid = ($urandom_range(0, 3) != 0);
      bus.i_waddr       = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      bus.i_wdata       = $urandom;
      tick();
    end
    rstn = 1'b1;
    idle();
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
